// File: rtl/pkt_fwd_if.sv
// Register-access, receive-byte and transmit-byte signals of pkt_fwd_queue.
interface pkt_fwd_if;
    logic [7:0]  addr;
    logic [31:0] din;
    logic        rw;
    logic        enable;
    logic [31:0] dout;
    logic [7:0]  rxd;
    logic        rx_vld;
    logic [7:0]  txd;
    logic        tx_vld;
    logic        tx_rdy;

    modport master (
        output addr, din, rw, enable, rxd, rx_vld, tx_rdy,
        input  dout, txd, tx_vld
    );

    modport slave (
        input  addr, din, rw, enable, rxd, rx_vld, tx_rdy,
        output dout, txd, tx_vld
    );
endinterface

// File: rtl/pkt_fwd_queue.sv
// Store-and-forward packet queue: preamble-checked Rx packets are buffered, then replayed on Tx.
// Optional RX_OK/RX_DROP/TX_OK counters are built when PKT_FWD_STATS_EN is defined.
module pkt_fwd_queue #(
    parameter int DEPTH    = 1024,
    parameter int MAX_PKTS = 4
) (
    input  logic     clk,
    input  logic     rst,
    pkt_fwd_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(MAX_PKTS);
    localparam int LW = 13;
    localparam logic [AW:0]   BUF_SZ  = DEPTH[AW:0];
    localparam logic [DW:0]   DESC_SZ = MAX_PKTS[DW:0];
    localparam logic [LW-1:0] DEPTH_L = DEPTH[LW-1:0];

    typedef enum logic [2:0] {RX_IDLE, RX_SFD, RX_RECV, RX_COMMIT, RX_DROP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_GAP} tx_state_t;

    rx_state_t     rx_state, rx_next;
    tx_state_t     tx_state, tx_next;

    logic [7:0]    mem [DEPTH];
    logic [LW-1:0] desc_mem [MAX_PKTS];

    logic [AW:0]   wr_com, wr_spec, rd_ptr, tx_pos;
    logic [DW:0]   dwr, drd;
    logic [LW-1:0] rx_len, tx_rem, min_size, max_size;
    logic          pkt_en, gap_cnt, tx_vld, wr_en;
    logic [7:0]    txd;

    logic [AW:0]   spec_used, com_used;
    logic [DW:0]   desc_cnt;
    logic [4:0]    cnt5;
    logic [LW-1:0] desc_head, free_bytes;
    logic          buf_full, desc_full, desc_empty;
    logic          rx_store, rx_push, rx_roll, rx_drop_ev;
    logic          tx_load, tx_adv, tx_pop;

    // Occupancy is measured against the committed read pointer, which only moves on pop
    assign spec_used  = wr_spec - rd_ptr;
    assign com_used   = wr_com - rd_ptr;
    assign buf_full   = (spec_used == BUF_SZ);
    assign desc_cnt   = dwr - drd;
    assign cnt5       = 5'(desc_cnt);
    assign desc_full  = (desc_cnt == DESC_SZ);
    assign desc_empty = (dwr == drd);
    assign desc_head  = desc_mem[drd[DW-1:0]];
    assign free_bytes = DEPTH_L - LW'(com_used);
    assign wr_en      = bus.enable && !bus.rw;
    assign bus.txd    = txd;
    assign bus.tx_vld = tx_vld;

    // FSM state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            tx_state <= TX_IDLE;
        end else begin
            rx_state <= rx_next;
            tx_state <= tx_next;
        end
    end

    // Rx next state and buffer-pointer controls
    always_comb begin
        rx_next    = rx_state;
        rx_store   = 1'b0;
        rx_push    = 1'b0;
        rx_roll    = 1'b0;
        rx_drop_ev = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!bus.rx_vld) begin
                    rx_next = RX_IDLE;
                end else if (pkt_en && bus.rxd == 8'h55 && !buf_full) begin
                    rx_next  = RX_SFD;
                    rx_store = 1'b1;
                end else begin
                    rx_next    = RX_DROP;
                    rx_drop_ev = 1'b1;
                end
            end
            RX_SFD: begin
                if (bus.rx_vld && bus.rxd == 8'hD5 && !buf_full) begin
                    rx_next  = RX_RECV;
                    rx_store = 1'b1;
                end else begin
                    rx_next    = RX_DROP;
                    rx_drop_ev = 1'b1;
                end
            end
            RX_RECV: begin
                if (!bus.rx_vld) begin
                    rx_next = RX_COMMIT;
                end else if (rx_len >= max_size || buf_full) begin
                    rx_next    = RX_DROP;
                    rx_drop_ev = 1'b1;
                end else begin
                    rx_store = 1'b1;
                end
            end
            RX_COMMIT: begin
                rx_next = RX_IDLE;
                if (rx_len >= min_size && !desc_full) begin
                    rx_push = 1'b1;
                end else begin
                    rx_roll    = 1'b1;
                    rx_drop_ev = 1'b1;
                end
            end
            RX_DROP: begin
                rx_roll = 1'b1;
                if (bus.rx_vld) begin
                    rx_next = RX_DROP;
                end else begin
                    rx_next = RX_IDLE;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    // Tx next state; the last byte's handshake pops the descriptor in the same cycle
    always_comb begin
        tx_next = tx_state;
        tx_load = 1'b0;
        tx_adv  = 1'b0;
        tx_pop  = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!desc_empty) begin
                    tx_next = TX_SEND;
                    tx_load = 1'b1;
                end else begin
                    tx_next = TX_IDLE;
                end
            end
            TX_SEND: begin
                if (!tx_vld || bus.tx_rdy) begin
                    if (tx_rem != 13'd0) begin
                        tx_adv = 1'b1;
                    end else begin
                        tx_pop  = 1'b1;
                        tx_next = TX_GAP;
                    end
                end else begin
                    tx_next = TX_SEND;
                end
            end
            TX_GAP: begin
                if (gap_cnt) begin
                    tx_next = TX_IDLE;
                end else begin
                    tx_next = TX_GAP;
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    // Pointers, lengths and registered Tx outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_com  <= '0;
            wr_spec <= '0;
            rd_ptr  <= '0;
            tx_pos  <= '0;
            dwr     <= '0;
            drd     <= '0;
            rx_len  <= 13'd0;
            tx_rem  <= 13'd0;
            txd     <= 8'h00;
            tx_vld  <= 1'b0;
            gap_cnt <= 1'b0;
        end else begin
            if (rx_store) begin
                wr_spec <= wr_spec + 1'b1;
                rx_len  <= (rx_state == RX_IDLE) ? 13'd1 : rx_len + 13'd1;
            end else if (rx_roll) begin
                wr_spec <= wr_com;
            end
            if (rx_push) begin
                dwr    <= dwr + 1'b1;
                wr_com <= wr_spec;
            end
            if (tx_load) begin
                tx_pos <= rd_ptr;
                tx_rem <= desc_head;
            end
            if (tx_adv) begin
                txd    <= mem[tx_pos[AW-1:0]];
                tx_vld <= 1'b1;
                tx_pos <= tx_pos + 1'b1;
                tx_rem <= tx_rem - 13'd1;
            end
            if (tx_pop) begin
                tx_vld <= 1'b0;
                drd    <= drd + 1'b1;
                rd_ptr <= rd_ptr + desc_head[AW:0];
            end
            gap_cnt <= (tx_state == TX_GAP) ? ~gap_cnt : 1'b0;
        end
    end

    // Packet bytes and descriptor lengths; contents need no reset
    always_ff @(posedge clk) begin
        if (rx_store) mem[wr_spec[AW-1:0]] <= bus.rxd;
        if (rx_push)  desc_mem[dwr[DW-1:0]] <= rx_len;
    end

    // Configuration registers with range-checked size limits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_en   <= 1'b0;
            min_size <= 13'd64;
            max_size <= 13'd512;
        end else if (wr_en) begin
            case (bus.addr)
                8'h00: pkt_en <= bus.din[0];
                8'h04: if (bus.din >= 32'd64 && bus.din < {19'd0, max_size}) min_size <= bus.din[12:0];
                8'h08: if (bus.din > {19'd0, min_size} && bus.din <= 32'(DEPTH)) max_size <= bus.din[12:0];
                default: ;
            endcase
        end
    end

`ifdef PKT_FWD_STATS_EN
    logic [31:0] rx_ok_cnt, rx_drop_cnt, tx_ok_cnt;

    // Saturating statistics; a write to a counter's address clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_ok_cnt   <= 32'd0;
            rx_drop_cnt <= 32'd0;
            tx_ok_cnt   <= 32'd0;
        end else begin
            if (wr_en && bus.addr == 8'h10)    rx_ok_cnt <= 32'd0;
            else if (rx_push && ~&rx_ok_cnt)   rx_ok_cnt <= rx_ok_cnt + 32'd1;
            if (wr_en && bus.addr == 8'h14)       rx_drop_cnt <= 32'd0;
            else if (rx_drop_ev && ~&rx_drop_cnt) rx_drop_cnt <= rx_drop_cnt + 32'd1;
            if (wr_en && bus.addr == 8'h18)    tx_ok_cnt <= 32'd0;
            else if (tx_pop && ~&tx_ok_cnt)    tx_ok_cnt <= tx_ok_cnt + 32'd1;
        end
    end
`endif

    // Combinational register read mux
    always_comb begin
        bus.dout = 32'd0;
        case (bus.addr)
            8'h00: bus.dout = {31'd0, pkt_en};
            8'h04: bus.dout = {19'd0, min_size};
            8'h08: bus.dout = {19'd0, max_size};
            8'h0C: bus.dout = {11'd0, free_bytes, 3'd0, cnt5};
`ifdef PKT_FWD_STATS_EN
            8'h10: bus.dout = rx_ok_cnt;
            8'h14: bus.dout = rx_drop_cnt;
            8'h18: bus.dout = tx_ok_cnt;
`endif
            default: bus.dout = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_pkt_fwd_queue.sv
// Directed bench for pkt_fwd_queue: register table plus packet forwarding sequences.
`timescale 1ns/1ps
module tb_pkt_fwd_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hold_err = 0;
    logic [7:0] got_data[$];
    int         got_cyc[$];
    logic [7:0] exp_data[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_txd = 8'h00;

    typedef struct {
        logic        is_wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [26];

    pkt_fwd_if bus();
    pkt_fwd_queue #(.DEPTH(1024), .MAX_PKTS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Collect transfers and watch that a stalled byte is held
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (bus.tx_vld && bus.tx_rdy) begin
                got_data.push_back(bus.txd);
                got_cyc.push_back(cyc);
            end
            if (prev_stall && (!bus.tx_vld || bus.txd !== prev_txd)) hold_err <= hold_err + 1;
            prev_stall <= bus.tx_vld && !bus.tx_rdy;
            prev_txd   <= bus.txd;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_true(input string name, input bit cond);
        checks++;
        if (!cond) begin
            errors++;
            $display("FAIL %s: condition false, expected true", name);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
        bus.addr = a; bus.din = d; bus.rw = 1'b0; bus.enable = 1'b1;
        @(posedge clk); #1;
        bus.enable = 1'b0; bus.rw = 1'b1;
    endtask

    task automatic reg_rd(input logic [7:0] a, output logic [31:0] d);
        bus.addr = a; bus.rw = 1'b1; bus.enable = 1'b1;
        #1 d = bus.dout;
        bus.enable = 1'b0;
    endtask

    function automatic logic [31:0] stat(input int cnt, input int free);
        return (32'(free) << 8) | 32'(cnt);
    endfunction

    function automatic logic [7:0] pbyte(input int i, input int seed);
        return 8'((i * 7 + seed) & 255);
    endfunction

    // Drives a packet, then two idle cycles so the commit completes
    task automatic send_pkt(input int len, input int seed, input logic [7:0] b0,
                            input logic [7:0] b1, input bit keep);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            b = (i == 0) ? b0 : (i == 1) ? b1 : pbyte(i, seed);
            bus.rx_vld = 1'b1; bus.rxd = b;
            if (keep) exp_data.push_back(b);
            @(posedge clk); #1;
        end
        bus.rx_vld = 1'b0; bus.rxd = 8'h00;
        step(2);
    endtask

    task automatic wait_bytes(input int n, input int budget, input string name);
        int k = 0;
        while (got_data.size() < n && k < budget) begin @(posedge clk); #1; k++; end
        check(name, 32'(got_data.size()), 32'(n));
    endtask

    task automatic compare_out(input string name);
        int mism = 0;
        check({name, "_len"}, 32'(got_data.size()), 32'(exp_data.size()));
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++)
            if (got_data[i] !== exp_data[i]) mism++;
        check({name, "_data"}, 32'(mism), 32'd0);
        got_data.delete(); got_cyc.delete(); exp_data.delete();
    endtask

    initial begin
        logic [31:0] r;
        int t0, n0, bad;
        vecs[0]  = '{1'b0, 8'h00, 32'd0,    32'd0};
        vecs[1]  = '{1'b0, 8'h04, 32'd0,    32'd64};
        vecs[2]  = '{1'b0, 8'h08, 32'd0,    32'd512};
        vecs[3]  = '{1'b0, 8'h0C, 32'd0,    32'h0004_0000};
        vecs[4]  = '{1'b0, 8'h14, 32'd0,    32'd0};
        vecs[5]  = '{1'b0, 8'h20, 32'd0,    32'd0};
        vecs[6]  = '{1'b1, 8'h04, 32'd32,   32'd0};
        vecs[7]  = '{1'b0, 8'h04, 32'd0,    32'd64};
        vecs[8]  = '{1'b1, 8'h04, 32'd512,  32'd0};
        vecs[9]  = '{1'b0, 8'h04, 32'd0,    32'd64};
        vecs[10] = '{1'b1, 8'h04, 32'd100,  32'd0};
        vecs[11] = '{1'b0, 8'h04, 32'd0,    32'd100};
        vecs[12] = '{1'b1, 8'h08, 32'd100,  32'd0};
        vecs[13] = '{1'b0, 8'h08, 32'd0,    32'd512};
        vecs[14] = '{1'b1, 8'h08, 32'd2000, 32'd0};
        vecs[15] = '{1'b0, 8'h08, 32'd0,    32'd512};
        vecs[16] = '{1'b1, 8'h08, 32'd1024, 32'd0};
        vecs[17] = '{1'b0, 8'h08, 32'd0,    32'd1024};
        vecs[18] = '{1'b1, 8'h08, 32'd512,  32'd0};
        vecs[19] = '{1'b0, 8'h08, 32'd0,    32'd512};
        vecs[20] = '{1'b1, 8'h04, 32'd64,   32'd0};
        vecs[21] = '{1'b0, 8'h04, 32'd0,    32'd64};
        vecs[22] = '{1'b1, 8'h0C, 32'd5,    32'd0};
        vecs[23] = '{1'b0, 8'h0C, 32'd0,    32'h0004_0000};
        vecs[24] = '{1'b1, 8'h00, 32'd1,    32'd0};
        vecs[25] = '{1'b0, 8'h00, 32'd0,    32'd1};

        bus.addr = 8'h00; bus.din = 32'd0; bus.rw = 1'b1; bus.enable = 1'b0;
        bus.rxd = 8'h00; bus.rx_vld = 1'b0; bus.tx_rdy = 1'b1;
        step(3);
        check("rst_tx_vld", {31'd0, bus.tx_vld}, 32'd0);
        check("rst_txd", {24'd0, bus.txd}, 32'd0);
        rst = 1'b0;
        step(1);

        for (int i = 0; i < 26; i++) begin
            if (vecs[i].is_wr) begin
                reg_wr(vecs[i].addr, vecs[i].data);
            end else begin
                reg_rd(vecs[i].addr, r);
                check($sformatf("vec%0d_addr%0h", i, vecs[i].addr), r, vecs[i].exp);
            end
        end

        // 100-byte packet forwarded intact and contiguous
        send_pkt(100, 3, 8'h55, 8'hD5, 1'b1);
        t0 = cyc;
        reg_rd(8'h0C, r);
        check("fwd100_status_stored", r, stat(1, 924));
        wait_bytes(100, 400, "fwd100_wait");
        if (got_cyc.size() == 100) begin
            check_true("fwd100_latency", got_cyc[0] <= t0 + 2);
            check("fwd100_contig", 32'(got_cyc[99] - got_cyc[0]), 32'd99);
        end
        step(3);
        reg_rd(8'h0C, r);
        check("fwd100_status_empty", r, stat(0, 1024));
        compare_out("fwd100");
`ifdef PKT_FWD_STATS_EN
        reg_rd(8'h10, r); check("stat_rx_ok", r, 32'd1);
        reg_rd(8'h18, r); check("stat_tx_ok", r, 32'd1);
`endif

        // Undersized and oversized packets are dropped
        send_pkt(40, 4, 8'h55, 8'hD5, 1'b0);
        step(10);
        check("short_no_tx", 32'(got_data.size()), 32'd0);
`ifdef PKT_FWD_STATS_EN
        reg_rd(8'h14, r); check("stat_rx_drop", r, 32'd1);
`endif
        send_pkt(600, 8, 8'h55, 8'hD5, 1'b0);
        step(10);
        check("long_no_tx", 32'(got_data.size()), 32'd0);
        reg_rd(8'h0C, r);
        check("long_free_restored", r, stat(0, 1024));
`ifdef PKT_FWD_STATS_EN
        reg_rd(8'h14, r); check("stat_rx_drop2", r, 32'd2);
        reg_wr(8'h14, 32'h1234);
        reg_rd(8'h14, r); check("stat_drop_clear", r, 32'd0);
`endif

        // Bad preamble bytes, then a good packet
        send_pkt(70, 5, 8'h12, 8'hD5, 1'b0);
        send_pkt(70, 6, 8'h55, 8'h00, 1'b0);
        send_pkt(70, 9, 8'h55, 8'hD5, 1'b1);
        wait_bytes(70, 300, "badpre_wait");
        step(10);
        compare_out("badpre");

        // Sink stalling every other cycle
        bus.tx_rdy = 1'b0;
        send_pkt(64, 11, 8'h55, 8'hD5, 1'b1);
        begin
            int k = 0;
            while (got_data.size() < 64 && k < 400) begin
                bus.tx_rdy = ~bus.tx_rdy;
                @(posedge clk); #1; k++;
            end
        end
        bus.tx_rdy = 1'b1;
        step(5);
        compare_out("stall64");
        check("stall_hold", 32'(hold_err), 32'd0);

        // Five packets into a four-entry descriptor FIFO
        bus.tx_rdy = 1'b0;
        for (int k = 0; k < 5; k++) send_pkt(200, 20 + k, 8'h55, 8'hD5, k < 4);
        step(2);
        reg_rd(8'h0C, r);
        check("five_status", r, stat(4, 224));
        bus.tx_rdy = 1'b1;
        wait_bytes(800, 3000, "five_wait");
        step(10);
        if (got_cyc.size() == 800) begin
            bad = 0;
            for (int k = 0; k < 4; k++)
                if (got_cyc[200 * k + 199] - got_cyc[200 * k] != 199) bad++;
            check("five_contig", 32'(bad), 32'd0);
            for (int k = 1; k < 4; k++)
                check_true($sformatf("five_gap%0d", k), got_cyc[200 * k] - got_cyc[200 * k - 1] >= 3);
        end
        reg_rd(8'h0C, r);
        check("five_status_empty", r, stat(0, 1024));
        compare_out("five");

        // Reset in the middle of a transmit
        send_pkt(100, 30, 8'h55, 8'hD5, 1'b0);
        wait_bytes(30, 200, "rst_wait");
        rst = 1'b1;
        #1;
        check("rst_mid_tx_vld", {31'd0, bus.tx_vld}, 32'd0);
        check("rst_mid_txd", {24'd0, bus.txd}, 32'd0);
        step(2);
        rst = 1'b0;
        n0 = got_data.size();
        step(1);
        reg_rd(8'h0C, r); check("rst_status", r, stat(0, 1024));
        reg_rd(8'h00, r); check("rst_cfg", r, 32'd0);
        reg_rd(8'h04, r); check("rst_min", r, 32'd64);
        reg_rd(8'h08, r); check("rst_max", r, 32'd512);
        step(50);
        check("rst_no_partial", 32'(got_data.size()), 32'(n0));

        // pkt_en is clear after reset, so a valid packet is refused
        send_pkt(70, 2, 8'h55, 8'hD5, 1'b0);
        step(10);
        check("pkten_off_no_tx", 32'(got_data.size()), 32'(n0));
        reg_rd(8'h0C, r); check("pkten_off_status", r, stat(0, 1024));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
